// File: rtl/adap_quan_sched_if.sv
// Channel-side bundle of the shared ADAP_QUAN scheduler: per-channel
// requests and operands, the registered quantizer operands and the returned
// code. Channel n occupies slice n of each packed vector.
interface adap_quan_sched_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = 2
);
  logic [NCH-1:0]      REQ;
  logic [16*NCH-1:0]   D_IN;
  logic [13*NCH-1:0]   Y_IN;
  logic [2*NCH-1:0]    RATE_IN;
  logic [15:0]         Q_D;
  logic [12:0]         Q_Y;
  logic [1:0]          Q_RATE;
  logic [4:0]          Q_I;
  logic [4:0]          I_OUT;
  logic [CHW-1:0]      CH_OUT;
  logic [NCH-1:0]      DONE;
  logic                BUSY;

  // Requester/quantizer side
  modport master (
    output REQ, D_IN, Y_IN, RATE_IN, Q_I,
    input  Q_D, Q_Y, Q_RATE, I_OUT, CH_OUT, DONE, BUSY
  );

  // Scheduler side
  modport slave (
    input  REQ, D_IN, Y_IN, RATE_IN, Q_I,
    output Q_D, Q_Y, Q_RATE, I_OUT, CH_OUT, DONE, BUSY
  );
endinterface

// File: rtl/adap_quan_sched.sv
// Round-robin scheduler sharing one combinational ADAP_QUAN among NCH
// encoder channels. A granted channel's operands are registered onto Q_*,
// the code Q_I is captured one edge later and returned with a DONE pulse.
module adap_quan_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = 2
) (
  input logic               CLK,
  input logic               RESET,
  adap_quan_sched_if.slave  sched
);

  typedef enum logic {IDLE, EVAL} state_t;

  state_t         state_q, state_d;
  logic [CHW-1:0] cur_q, last_q;
  logic [CHW-1:0] win, idx;
  logic           win_vld;
  logic           load;
  logic [NCH-1:0] cur_oh, elig;

  logic [15:0]    qd_q;
  logic [12:0]    qy_q;
  logic [1:0]     qr_q;
  logic [4:0]     i_q;
  logic [CHW-1:0] ch_q;
  logic [NCH-1:0] done_q;
  logic           busy_q;

  // Eligible channels: a channel being evaluated or just completed is masked
  // so a requester still holding REQ on its DONE cycle is not granted twice.
  always_comb begin
    cur_oh         = '0;
    cur_oh[cur_q]  = 1'b1;
    elig           = sched.REQ & ~done_q & ((state_q == EVAL) ? ~cur_oh : '1);
  end

  // Rotating-priority pick: first eligible channel from last+1 upward, wrapping
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = last_q + CHW'(i);
      if (!win_vld && elig[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Next-state and grant decision
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          load    = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (win_vld) load = 1'b1;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand load, result capture and completion pulse
  always_ff @(posedge CLK) begin
    if (RESET) begin
      qd_q   <= '0;
      qy_q   <= '0;
      qr_q   <= '0;
      i_q    <= '0;
      ch_q   <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
      cur_q  <= '0;
      last_q <= '1;
    end else begin
      done_q <= '0;
      busy_q <= (state_d == EVAL);
      if (state_q == EVAL) begin
        i_q    <= sched.Q_I;
        ch_q   <= cur_q;
        done_q <= cur_oh;
      end
      if (load) begin
        qd_q   <= sched.D_IN[16*win +: 16];
        qy_q   <= sched.Y_IN[13*win +: 13];
        qr_q   <= sched.RATE_IN[2*win +: 2];
        cur_q  <= win;
        last_q <= win;
      end
    end
  end

  assign sched.Q_D    = qd_q;
  assign sched.Q_Y    = qy_q;
  assign sched.Q_RATE = qr_q;
  assign sched.I_OUT  = i_q;
  assign sched.CH_OUT = ch_q;
  assign sched.DONE   = done_q;
  assign sched.BUSY   = busy_q;

endmodule

// File: tb/tb_adap_quan_sched.sv
// Directed bench for adap_quan_sched with a stub quantizer (I = Q_D[4:0]).
// Each table row is one clock: inputs applied before the edge, outputs
// checked 1 ns after it.
module tb_adap_quan_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adap_quan_sched_if #(.NCH(4), .CHW(2)) bus ();

  adap_quan_sched #(.NCH(4), .CHW(2)) dut (
    .CLK   (clk),
    .RESET (rst),
    .sched (bus.slave)
  );

  assign bus.Q_I = bus.Q_D[4:0];

  typedef struct {
    logic        rst;
    logic        pat;
    logic [3:0]  req;
    logic        busy;
    logic [3:0]  done;
    logic [4:0]  i;
    logic [1:0]  ch;
    logic [15:0] qd;
    logic [12:0] qy;
    logic [1:0]  qr;
  } vec_t;

  vec_t tbl[$];
  int   n_run  = 0;
  int   n_fail = 0;
  logic [3:0] prev_done;

  function automatic vec_t mk(logic r, logic p, logic [3:0] rq, logic b, logic [3:0] d,
                              logic [4:0] i, logic [1:0] c, logic [15:0] qd,
                              logic [12:0] qy, logic [1:0] qr);
    vec_t v;
    v.rst = r; v.pat = p; v.req = rq; v.busy = b; v.done = d;
    v.i = i; v.ch = c; v.qd = qd; v.qy = qy; v.qr = qr;
    return v;
  endfunction

  // Pattern 0: ch n has D=n+1, Y=0x100+n, RATE=n. Pattern 1 overrides ch2.
  task automatic set_pattern(input logic p);
    for (int n = 0; n < 4; n++) begin
      bus.D_IN[16*n +: 16]  = 16'(n + 1);
      bus.Y_IN[13*n +: 13]  = 13'(13'h100 + n);
      bus.RATE_IN[2*n +: 2] = 2'(n);
    end
    if (p) begin
      bus.D_IN[32 +: 16]  = 16'h0013;
      bus.Y_IN[26 +: 13]  = 13'h0220;
      bus.RATE_IN[4 +: 2] = 2'b01;
    end
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.REQ = 4'b0000;
    set_pattern(1'b0);

    // Reset held 3 cycles with all channels requesting
    rst = 1'b1;
    bus.REQ = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_done", c, 32'(bus.DONE), 32'h0);
      chk("rst_busy", c, 32'(bus.BUSY), 32'h0);
      chk("rst_qd",   c, 32'(bus.Q_D), 32'h0);
      chk("rst_qy",   c, 32'(bus.Q_Y), 32'h0);
      chk("rst_qr",   c, 32'(bus.Q_RATE), 32'h0);
      chk("rst_i",    c, 32'(bus.I_OUT), 32'h0);
      chk("rst_ch",   c, 32'(bus.CH_OUT), 32'h0);
    end
    rst = 1'b0;
    step();
    chk("first_grant_qd", 0, 32'(bus.Q_D), 32'h1);
    chk("first_grant_busy", 0, 32'(bus.BUSY), 32'h1);
    bus.REQ = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Single channel (pattern 1)
    tbl.push_back(mk(0,1,4'b0100, 1,4'b0000,5'h00,2'd0,16'h0013,13'h0220,2'd1));
    tbl.push_back(mk(0,1,4'b0100, 0,4'b0100,5'h13,2'd2,16'h0013,13'h0220,2'd1));
    tbl.push_back(mk(0,1,4'b0000, 0,4'b0000,5'h13,2'd2,16'h0013,13'h0220,2'd1));
    // Round-robin, all four requesting, each dropping after its DONE
    tbl.push_back(mk(1,0,4'b0000, 0,4'b0000,5'h00,2'd0,16'h0000,13'h0000,2'd0));
    tbl.push_back(mk(0,0,4'b1111, 1,4'b0000,5'h00,2'd0,16'h0001,13'h0100,2'd0));
    tbl.push_back(mk(0,0,4'b1111, 1,4'b0001,5'h01,2'd0,16'h0002,13'h0101,2'd1));
    tbl.push_back(mk(0,0,4'b1110, 1,4'b0010,5'h02,2'd1,16'h0003,13'h0102,2'd2));
    tbl.push_back(mk(0,0,4'b1100, 1,4'b0100,5'h03,2'd2,16'h0004,13'h0103,2'd3));
    tbl.push_back(mk(0,0,4'b1000, 0,4'b1000,5'h04,2'd3,16'h0004,13'h0103,2'd3));
    tbl.push_back(mk(0,0,4'b0000, 0,4'b0000,5'h04,2'd3,16'h0004,13'h0103,2'd3));
    // Fairness: ch1 and ch3 requesting continuously
    tbl.push_back(mk(1,0,4'b0000, 0,4'b0000,5'h00,2'd0,16'h0000,13'h0000,2'd0));
    tbl.push_back(mk(0,0,4'b1010, 1,4'b0000,5'h00,2'd0,16'h0002,13'h0101,2'd1));
    tbl.push_back(mk(0,0,4'b1010, 1,4'b0010,5'h02,2'd1,16'h0004,13'h0103,2'd3));
    tbl.push_back(mk(0,0,4'b1010, 0,4'b1000,5'h04,2'd3,16'h0004,13'h0103,2'd3));
    tbl.push_back(mk(0,0,4'b1010, 1,4'b0000,5'h04,2'd3,16'h0002,13'h0101,2'd1));
    tbl.push_back(mk(0,0,4'b1010, 1,4'b0010,5'h02,2'd1,16'h0004,13'h0103,2'd3));
    tbl.push_back(mk(0,0,4'b1010, 0,4'b1000,5'h04,2'd3,16'h0004,13'h0103,2'd3));
    tbl.push_back(mk(0,0,4'b1010, 1,4'b0000,5'h04,2'd3,16'h0002,13'h0101,2'd1));
    tbl.push_back(mk(0,0,4'b0000, 0,4'b0010,5'h02,2'd1,16'h0002,13'h0101,2'd1));

    prev_done = 4'b0000;
    for (int r = 0; r < tbl.size(); r++) begin
      rst = tbl[r].rst;
      set_pattern(tbl[r].pat);
      bus.REQ = tbl[r].req;
      step();
      chk("busy",  r, 32'(bus.BUSY),   32'(tbl[r].busy));
      chk("done",  r, 32'(bus.DONE),   32'(tbl[r].done));
      chk("i_out", r, 32'(bus.I_OUT),  32'(tbl[r].i));
      chk("ch",    r, 32'(bus.CH_OUT), 32'(tbl[r].ch));
      chk("q_d",   r, 32'(bus.Q_D),    32'(tbl[r].qd));
      chk("q_y",   r, 32'(bus.Q_Y),    32'(tbl[r].qy));
      chk("q_rate",r, 32'(bus.Q_RATE), 32'(tbl[r].qr));
      chk("no_adjacent_done", r, 32'(bus.DONE & prev_done), 32'h0);
      prev_done = bus.DONE;
    end
    rst = 1'b0;

    // Reset on the cycle BUSY first rises abandons the evaluation
    set_pattern(1'b0);
    bus.REQ = 4'b0011;
    step();
    chk("mid_busy_rise", 0, 32'(bus.BUSY), 32'h1);
    chk("mid_qd_grant",  0, 32'(bus.Q_D),  32'h1);
    rst = 1'b1;
    step();
    chk("mid_rst_done", 0, 32'(bus.DONE),  32'h0);
    chk("mid_rst_busy", 0, 32'(bus.BUSY),  32'h0);
    chk("mid_rst_qd",   0, 32'(bus.Q_D),   32'h0);
    chk("mid_rst_qy",   0, 32'(bus.Q_Y),   32'h0);
    chk("mid_rst_i",    0, 32'(bus.I_OUT), 32'h0);
    rst = 1'b0;
    step();
    chk("restart_qd",   0, 32'(bus.Q_D),   32'h1);
    chk("restart_busy", 0, 32'(bus.BUSY),  32'h1);
    step();
    chk("restart_done", 0, 32'(bus.DONE),  32'h1);
    chk("restart_i",    0, 32'(bus.I_OUT), 32'h1);
    chk("restart_next_qd", 0, 32'(bus.Q_D), 32'h2);
    bus.REQ = 4'b0010;
    step();
    chk("restart_done2", 0, 32'(bus.DONE),  32'h2);
    chk("restart_i2",    0, 32'(bus.I_OUT), 32'h2);
    bus.REQ = 4'b0000;
    step();
    chk("restart_idle",  0, 32'(bus.BUSY),  32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
